// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_pkg
// Purpose  : Shared event-type codes and key FSM state encodings for the
//            button event controller.
// Revision : 1.0  initial release
// ============================================================================
package btn_pkg;

    // Event type codes. The numeric order is also the delivery priority
    // within one button (lower code is delivered first).
    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_LONG    = 2'd1;
    localparam logic [1:0] EV_REPEAT  = 2'd2;
    localparam logic [1:0] EV_RELEASE = 2'd3;

    // Number of distinct event types per button
    localparam int EV_TYPES = 4;

    // Key FSM state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;

    typedef enum logic [1:0] {
        KEY_IDLE    = ST_IDLE,
        KEY_PRESSED = ST_PRESSED,
        KEY_HELD    = ST_HELD
    } key_state_t;

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_event_ctrl_key_fsm.sv
`default_nettype none
// ============================================================================
// Module   : btn_key_fsm
// Purpose  : Press / long-press / auto-repeat state machine for one debounced
//            button. Advances only on the shared sample tick and emits
//            one-cycle raise pulses, one bit per event type.
// Revision : 1.0  initial release
// ============================================================================
module btn_key_fsm
    import btn_pkg::*;
#(
    parameter int LONG_TICKS   = 48,
    parameter int REPEAT_TICKS = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_tick,
    input  logic                i_s,
    output logic [EV_TYPES-1:0] o_raise
);

    localparam logic [7:0] c_LONG_LAST   = 8'(LONG_TICKS - 1);
    localparam logic [7:0] c_REPEAT_LAST = 8'(REPEAT_TICKS - 1);

    key_state_t          r_state;
    logic [7:0]          r_cnt;
    logic [EV_TYPES-1:0] r_raise;

    // State, hold counter and registered raise pulses; the compare uses the
    // counter value before increment, so LONG lands LONG_TICKS ticks after PRESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= KEY_IDLE;
            r_cnt   <= 8'd0;
            r_raise <= '0;
        end else begin
            r_raise <= '0;
            if (i_tick) begin
                case (r_state)
                    KEY_IDLE: begin
                        if (i_s) begin
                            r_state           <= KEY_PRESSED;
                            r_cnt             <= 8'd0;
                            r_raise[EV_PRESS] <= 1'b1;
                        end
                    end
                    KEY_PRESSED: begin
                        if (!i_s) begin
                            r_state             <= KEY_IDLE;
                            r_raise[EV_RELEASE] <= 1'b1;
                        end else if (r_cnt == c_LONG_LAST) begin
                            r_state          <= KEY_HELD;
                            r_cnt            <= 8'd0;
                            r_raise[EV_LONG] <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    KEY_HELD: begin
                        if (!i_s) begin
                            r_state             <= KEY_IDLE;
                            r_raise[EV_RELEASE] <= 1'b1;
                        end else if (r_cnt == c_REPEAT_LAST) begin
                            r_cnt              <= 8'd0;
                            r_raise[EV_REPEAT] <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    default: begin
                        r_state <= KEY_IDLE;
                        r_cnt   <= 8'd0;
                    end
                endcase
            end
        end
    end

    assign o_raise = r_raise;

endmodule : btn_key_fsm
`default_nettype wire

// File: rtl/btn_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : btn_event_ctrl
// Purpose  : Key-event controller: synchronises and tick-samples the buttons,
//            runs one key FSM per button, collects raised events in a pending
//            array and serialises them over a valid/ready port.
// Revision : 1.0  initial release
// ============================================================================
module btn_event_ctrl
    import btn_pkg::*;
#(
    parameter int          BT_WIDTH     = 8,
    parameter logic [19:0] TICK_CNT     = 20'hF_FFFF,
    parameter int          LONG_TICKS   = 48,
    parameter int          REPEAT_TICKS = 10,
    parameter logic        ACTIVE_LOW   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BT_WIDTH-1:0] btn_in,
    output logic [BT_WIDTH-1:0] btn_level,
    output logic                tick,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [1:0]          ev_type,
    output logic [5:0]          ev_idx,
    output logic                ev_drop
);

    // Pending bit layout: button b, type t lives at bit b*EV_TYPES + t, so the
    // lowest set bit is exactly the next event in delivery order.
    localparam int                  c_NPEND = EV_TYPES * BT_WIDTH;
    localparam logic [BT_WIDTH-1:0] c_POL   = {BT_WIDTH{ACTIVE_LOW}};

    logic [BT_WIDTH-1:0] r_sync1;
    logic [BT_WIDTH-1:0] r_sync2;
    logic [BT_WIDTH-1:0] r_level;
    logic [19:0]         r_tick_cnt;
    logic [c_NPEND-1:0]  r_pend;
    logic                r_valid;
    logic [1:0]          r_type;
    logic [5:0]          r_idx;
    logic                r_drop;

    logic [BT_WIDTH-1:0] w_s;
    logic                w_tick;
    logic [c_NPEND-1:0]  w_raise;
    logic [c_NPEND-1:0]  w_clr;
    logic                w_found;
    logic [7:0]          w_sel;
    logic                w_load;

    // Two-flop synchroniser; reset to the idle pin level so no phantom press appears
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= c_POL;
            r_sync2 <= c_POL;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s    = r_sync2 ^ c_POL;
    assign w_tick = (r_tick_cnt == TICK_CNT);

    // Free-running tick counter, wraps in the same cycle the tick strobe is high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= 20'd0;
        end else if (w_tick) begin
            r_tick_cnt <= 20'd0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 20'd1;
        end
    end

    // Debounced level is simply the synchronised value sampled on tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
        end else if (w_tick) begin
            r_level <= w_s;
        end
    end

    generate
        for (genvar gi = 0; gi < BT_WIDTH; gi++) begin : g_key
            btn_key_fsm #(
                .LONG_TICKS   (LONG_TICKS),
                .REPEAT_TICKS (REPEAT_TICKS)
            ) u_key (
                .clk     (clk),
                .rst     (rst),
                .i_tick  (w_tick),
                .i_s     (w_s[gi]),
                .o_raise (w_raise[gi*EV_TYPES +: EV_TYPES])
            );
        end
    endgenerate

    // Priority select: lowest set pending bit wins
    always_comb begin
        w_found = 1'b0;
        w_sel   = 8'd0;
        for (int i = c_NPEND - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_found = 1'b1;
                w_sel   = 8'(i);
            end
        end
    end

    assign w_load = (!r_valid || ev_ready) && w_found;
    assign w_clr  = w_load ? ({{(c_NPEND-1){1'b0}}, 1'b1} << w_sel) : '0;

    // Pending array: a raise always wins over the load-cycle clear; a raise onto
    // a bit that stays set loses that event and is reported as a drop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_drop <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_raise;
            r_drop <= |(w_raise & r_pend & ~w_clr);
        end
    end

    // Output register: refills whenever empty or being consumed; fields hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_type  <= 2'd0;
            r_idx   <= 6'd0;
        end else if (!r_valid || ev_ready) begin
            r_valid <= w_found;
            if (w_found) begin
                r_type <= w_sel[1:0];
                r_idx  <= w_sel[7:2];
            end
        end
    end

    assign btn_level = r_level;
    assign tick      = w_tick;
    assign ev_valid  = r_valid;
    assign ev_type   = r_type;
    assign ev_idx    = r_idx;
    assign ev_drop   = r_drop;

endmodule : btn_event_ctrl
`default_nettype wire

// File: tb/tb_btn_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_event_ctrl
// Purpose  : Directed self-checking bench for btn_event_ctrl with a short
//            tick period and small long/repeat thresholds.
// Revision : 1.0  initial release
// ============================================================================
module tb_btn_event_ctrl;

    localparam int c_BT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [c_BT-1:0] btn_in;
    logic [c_BT-1:0] btn_level;
    logic            tick;
    logic            ev_valid;
    logic            ev_ready;
    logic [1:0]      ev_type;
    logic [5:0]      ev_idx;
    logic            ev_drop;

    int checks = 0;
    int errors = 0;

    // Monitor state (written only by the monitor process)
    logic [7:0] evq[$];
    int         evt[$];
    int         tick_no = 0;
    int         drops   = 0;

    always #5 clk = ~clk;

    btn_event_ctrl #(
        .BT_WIDTH     (c_BT),
        .TICK_CNT     (20'd3),
        .LONG_TICKS   (4),
        .REPEAT_TICKS (2),
        .ACTIVE_LOW   (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .tick      (tick),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_type   (ev_type),
        .ev_idx    (ev_idx),
        .ev_drop   (ev_drop)
    );

    // Log every accepted event with the number of the tick that produced it
    always @(negedge clk) begin
        if (!rst) begin
            if (tick) tick_no++;
            if (ev_valid && ev_ready) begin
                evq.push_back({ev_idx, ev_type});
                evt.push_back(tick_no);
            end
            if (ev_drop) drops++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 20);
        if (!tick) fail("tick_wait");
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 ev_ready = v;
    endtask

    task automatic pop_ev(input string tag, input logic [1:0] et, input logic [5:0] ei,
                          output int t);
        int         n;
        logic [7:0] e;
        n = 0;
        t = -1;
        do begin
            @(posedge clk);
            n++;
        end while (evq.size() == 0 && n < 60);
        if (evq.size() == 0) begin
            fail(tag);
        end else begin
            e = evq.pop_front();
            t = evt.pop_front();
            chk({tag, "_type"}, 32'(e[1:0]), 32'(et));
            chk({tag, "_idx"},  32'(e[7:2]), 32'(ei));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, tp, tl, tr1, tr2, tr3, trl, tx;

        rst      = 1'b1;
        btn_in   = '0;
        ev_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_type",  32'(ev_type), 0);
        chk("rst_idx",   32'(ev_idx), 0);
        chk("rst_drop",  32'(ev_drop), 0);
        chk("rst_level", 32'(btn_level), 0);
        chk("rst_tick",  32'(tick), 0);

        // First tick lands at cycle TICK_CNT after reset release
        rst = 1'b0;
        @(negedge clk);
        chk("tick_c1", 32'(tick), 0);
        @(negedge clk);
        @(negedge clk);
        chk("tick_c3", 32'(tick), 1);

        // 1: tap button 2 for two ticks
        d0 = drops;
        btn_in[2] = 1'b1;
        wait_tick();
        @(negedge clk);
        chk("t1_level", 32'(btn_level[2]), 1);
        chk("t1_lat1", 32'(ev_valid), 0);
        @(negedge clk);
        chk("t1_lat2", 32'(ev_valid), 0);
        @(negedge clk);
        chk("t1_lat3", 32'(ev_valid), 1);
        wait_tick();
        btn_in[2] = 1'b0;
        pop_ev("t1_press", 2'd0, 6'd2, tx);
        pop_ev("t1_rel",   2'd3, 6'd2, tx);
        repeat (6) wait_tick();
        chk("t1_nolong", 32'(evq.size()), 0);
        chk("t1_drop", 32'(drops - d0), 0);

        // 2: hold button 0 for 11 sampled ticks
        wait_tick();
        btn_in[0] = 1'b1;
        repeat (5) wait_tick();
        chk("t2_level", 32'(btn_level[0]), 1);
        repeat (6) wait_tick();
        btn_in[0] = 1'b0;
        pop_ev("t2_press", 2'd0, 6'd0, tp);
        pop_ev("t2_long",  2'd1, 6'd0, tl);
        pop_ev("t2_rep1",  2'd2, 6'd0, tr1);
        pop_ev("t2_rep2",  2'd2, 6'd0, tr2);
        pop_ev("t2_rep3",  2'd2, 6'd0, tr3);
        pop_ev("t2_rel",   2'd3, 6'd0, trl);
        chk("t2_long_dly", 32'(tl - tp), 4);
        chk("t2_rep1_dly", 32'(tr1 - tl), 2);
        chk("t2_rep2_dly", 32'(tr2 - tr1), 2);
        chk("t2_rep3_dly", 32'(tr3 - tr2), 2);
        chk("t2_rel_dly",  32'(trl - tr3), 1);
        repeat (3) wait_tick();
        chk("t2_empty", 32'(evq.size()), 0);

        // 3: buttons 3 and 1 together while the consumer stalls
        set_ready(1'b0);
        wait_tick();
        btn_in = 4'b1010;
        wait_tick();
        wait_tick();
        btn_in = 4'b0000;
        wait_tick();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 32'(ev_valid), 1);
            chk("t3_hold_idx",   32'(ev_idx), 1);
            chk("t3_hold_type",  32'(ev_type), 0);
        end
        set_ready(1'b1);
        // Lowest button first: button 1 drains both its events before button 3
        pop_ev("t3_p1", 2'd0, 6'd1, tp);
        pop_ev("t3_r1", 2'd3, 6'd1, tx);
        pop_ev("t3_p3", 2'd0, 6'd3, tx);
        pop_ev("t3_r3", 2'd3, 6'd3, tx);
        chk("t3_b2b", 32'(tx - tp), 0);

        // 4: bounce button 1 every clk, always low at the sampled point
        d0 = drops;
        for (int k = 0; k < 5; k++) begin
            wait_tick();
            btn_in[1] = 1'b0;
            @(negedge clk);
            btn_in[1] = 1'b1;
            @(negedge clk);
            btn_in[1] = 1'b0;
            @(negedge clk);
            btn_in[1] = 1'b1;
        end
        btn_in[1] = 1'b0;
        repeat (3) wait_tick();
        chk("t4_noev", 32'(evq.size()), 0);
        chk("t4_level", 32'(btn_level[1]), 0);
        chk("t4_drop", 32'(drops - d0), 0);

        // 5: hold button 0 for 9 ticks with the consumer stalled
        d0 = drops;
        set_ready(1'b0);
        wait_tick();
        btn_in[0] = 1'b1;
        repeat (9) wait_tick();
        btn_in[0] = 1'b0;
        wait_tick();
        repeat (4) @(negedge clk);
        chk("t5_drop", 32'(drops - d0), 1);
        set_ready(1'b1);
        pop_ev("t5_press", 2'd0, 6'd0, tx);
        pop_ev("t5_long",  2'd1, 6'd0, tx);
        pop_ev("t5_rep",   2'd2, 6'd0, tx);
        pop_ev("t5_rel",   2'd3, 6'd0, tx);
        repeat (8) @(negedge clk);
        chk("t5_onerep", 32'(evq.size()), 0);

        // 6: reset while an event is held and another is pending
        set_ready(1'b0);
        wait_tick();
        btn_in = 4'b0101;
        wait_tick();
        wait_tick();
        repeat (2) @(negedge clk);
        chk("t6_pre_valid", 32'(ev_valid), 1);
        rst    = 1'b1;
        btn_in = 4'b0000;
        @(negedge clk);
        chk("t6_valid", 32'(ev_valid), 0);
        chk("t6_level", 32'(btn_level), 0);
        chk("t6_drop",  32'(ev_drop), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_ready(1'b1);
        repeat (6) wait_tick();
        chk("t6_nostale", 32'(evq.size()), 0);
        chk("t6_idle_valid", 32'(ev_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_btn_event_ctrl
`default_nettype wire
